// File: rtl/l2_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_sched_pkg
// Description : Shared types and defaults for the l2 pulse scheduler.
//               Holds the scheduler state encoding, default pulse timing,
//               and a small helper for sizing the phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_sched_pkg;

  // Default pulse timing in clk cycles (100 ns high / 100 ns low at 20 ns clk)
  localparam int unsigned c_DEF_HIGH_CYC = 5;
  localparam int unsigned c_DEF_LOW_CYC  = 5;
  localparam int unsigned c_DEF_NW       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : l2_rr_arb2
// Description : Two-way round-robin arbiter. Grant is combinational and only
//               produced while en_i is high; the priority pointer advances
//               to the other requester whenever a grant is issued.
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-low reset
//               req_i  - request vector [1:0]
//               en_i   - arbitration enable
//               gnt_o  - one-hot grant vector [1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module l2_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Preferred requester on a tie; 0 after reset so requester 0 wins first.
  logic ptr_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else if (en_i && (|req_i)) begin
      // Hand priority to whoever was not just served.
      ptr_q <= ~gnt_o[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_pulse_sched.sv
`default_nettype none
// ============================================================================
// Module      : l2_pulse_sched
// Description : Shares the l2 pulse-counting datapath between two requesters.
//               A round-robin arbiter grants one burst of N pulses at a time;
//               count_o carries the pulses to l2.count, and rising edges of
//               l2.cnt (cnt_i) are counted as acknowledgements.
// Ports       : clk, rst (async active-low)
//               req0/num0, req1/num1 - requests (level) and burst lengths
//               gnt0/gnt1            - 1-cycle grant pulses
//               done0/done1          - 1-cycle completion pulses
//               busy                 - grant cycle through done cycle
//               count_o              - pulse train to l2.count
//               cnt_i                - l2.cnt, synchronous to clk
//               ack_cnt              - saturating count of cnt_i rising edges
// Revision    : 1.0 - initial release
// ============================================================================
module l2_pulse_sched
  import l2_sched_pkg::*;
#(
  parameter int unsigned HIGH_CYC = c_DEF_HIGH_CYC,
  parameter int unsigned LOW_CYC  = c_DEF_LOW_CYC,
  parameter int unsigned NW       = c_DEF_NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [NW-1:0] num0,
  input  logic          req1,
  input  logic [NW-1:0] num1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          busy,
  output logic          count_o,
  input  logic          cnt_i,
  output logic [NW-1:0] ack_cnt
);

  localparam int unsigned MAXC = max2(HIGH_CYC, LOW_CYC);
  localparam int unsigned PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [PW-1:0] c_HIGH_LAST = PW'(HIGH_CYC - 1);
  localparam logic [PW-1:0] c_LOW_LAST  = PW'(LOW_CYC - 1);

  sched_state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [NW-1:0] rem_q, rem_d;
  logic          id_q, id_d;
  logic          zero_q, zero_d;
  logic [NW-1:0] ack_q, ack_d;
  logic          cnt_q, cnt_prev_q;
  logic          gnt0_q, gnt1_q, done0_q, done1_q, busy_q, count_q;

  logic          w_arb_en;
  logic [1:0]    w_arb_gnt;
  logic          w_fire;
  logic          w_done_fire;
  logic          w_busy_d;
  logic          w_cnt_rise;

  assign w_arb_en = (state_q == ST_IDLE);

  l2_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({req1, req0}),
    .en_i  (w_arb_en),
    .gnt_o (w_arb_gnt)
  );

  assign w_fire = w_arb_en & (|w_arb_gnt);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    id_d    = id_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (|w_arb_gnt) begin
          id_d    = w_arb_gnt[1];
          rem_d   = w_arb_gnt[1] ? num1 : num0;
          phase_d = '0;
          zero_d  = (rem_d == '0);
          state_d = zero_d ? ST_DONE : ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_q == c_HIGH_LAST) begin
          phase_d = '0;
          rem_d   = rem_q - NW'(1);
          state_d = ST_LOW;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_LOW: begin
        if (phase_q == c_LOW_LAST) begin
          phase_d = '0;
          state_d = (rem_q != '0) ? ST_HIGH : ST_DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A zero-length burst enters DONE straight from IDLE, so its grant lands in
  // the DONE cycle; its done pulse is deferred one cycle so grant and done
  // remain distinct pulses. Normal bursts report done in the DONE cycle.
  assign w_done_fire = ((state_d == ST_DONE) && (state_q != ST_IDLE)) ||
                       ((state_q == ST_DONE) && zero_q);
  assign w_busy_d    = (state_d != ST_IDLE) || ((state_q == ST_DONE) && zero_q);

  // Acknowledge counting on registered cnt_i; edges are ignored while idle
  // so the last burst's count is held.
  assign w_cnt_rise = cnt_q & ~cnt_prev_q;

  always_comb begin
    ack_d = ack_q;
    if (w_fire) begin
      ack_d = '0;
    end else if (w_cnt_rise && (state_q != ST_IDLE) && (ack_q != '1)) begin
      ack_d = ack_q + NW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      rem_q      <= '0;
      id_q       <= 1'b0;
      zero_q     <= 1'b0;
      ack_q      <= '0;
      cnt_q      <= 1'b0;
      cnt_prev_q <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      zero_q     <= zero_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_i;
      cnt_prev_q <= cnt_q;
      gnt0_q     <= w_fire & w_arb_gnt[0];
      gnt1_q     <= w_fire & w_arb_gnt[1];
      done0_q    <= w_done_fire & ~id_q;
      done1_q    <= w_done_fire & id_q;
      busy_q     <= w_busy_d;
      count_q    <= (state_d == ST_HIGH);
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign busy    = busy_q;
  assign count_o = count_q;
  assign ack_cnt = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_pulse_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_pulse_sched
// Description : Self-checking bench for l2_pulse_sched. Expected grant/done
//               events are queued when stimulus is applied and compared as
//               the DUT emits them, together with pulse shape, busy length
//               and acknowledge count of each burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_pulse_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] num0 = '0, num1 = '0;
  logic       gnt0, gnt1, done0, done1, busy, count_o, cnt_i;
  logic [3:0] ack_cnt;

  logic       echo_en = 1'b0;
  logic       cnt_man = 1'b0;
  logic [1:0] dly = 2'b00;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit is_done;
    bit id;
    int delta;   // cycles since previous event, -1 = don't care
    int n;
    int ack;
  } exp_t;

  exp_t sbq[$];

  l2_pulse_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .num0    (num0),
    .req1    (req1),
    .num1    (num1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .busy    (busy),
    .count_o (count_o),
    .cnt_i   (cnt_i),
    .ack_cnt (ack_cnt)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // l2 model: cnt echoes count_o two cycles later
  always @(posedge clk) dly <= {dly[0], count_o};
  assign cnt_i = echo_en ? dly[1] : cnt_man;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return gnt0;
      1:       return gnt1;
      2:       return done0;
      default: return done1;
    endcase
  endfunction

  task automatic wait_for(input int s, input int maxc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sig(s) && k < maxc);
    if (!sig(s)) chk($sformatf("timeout_sig%0d", s), 0, 1);
  endtask

  task automatic push(input bit is_done, input bit id, input int delta,
                      input int n, input int ack);
    exp_t e;
    e.is_done = is_done;
    e.id      = id;
    e.delta   = delta;
    e.n       = n;
    e.ack     = ack;
    sbq.push_back(e);
  endtask

  // Scoreboard monitor
  int   last_ev   = 0;
  bit   have_last = 0;
  bit   in_burst  = 0;
  int   hi_cnt, rises, busy_cnt;
  logic prev_co   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      in_burst  = 0;
      have_last = 0;
      prev_co   = 1'b0;
    end else begin
      if (in_burst) begin
        hi_cnt   += int'(count_o);
        busy_cnt += int'(busy);
        if (count_o && !prev_co) rises++;
      end
      prev_co = count_o;
      if (gnt0 || gnt1) begin
        chk("gnt_excl", int'(gnt0 & gnt1), 0);
        if (sbq.size() == 0) begin
          chk("gnt_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("gnt_kind", int'(e.is_done), 0);
          chk("gnt_id", int'(gnt1), int'(e.id));
          if (e.delta >= 0 && have_last) chk("gnt_delay", cyc - last_ev, e.delta);
          chk("gnt_ack_clr", int'(ack_cnt), 0);
        end
        last_ev   = cyc;
        have_last = 1;
        in_burst  = 1;
        hi_cnt    = int'(count_o);
        rises     = int'(count_o);
        busy_cnt  = int'(busy);
      end
      if (done0 || done1) begin
        chk("done_excl", int'(done0 & done1), 0);
        if (sbq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("done_kind", int'(e.is_done), 1);
          chk("done_id", int'(done1), int'(e.id));
          if (e.delta >= 0 && have_last) chk("done_delay", cyc - last_ev, e.delta);
          chk("burst_high_cyc", hi_cnt, e.n * 5);
          chk("burst_pulses", rises, e.n);
          chk("burst_busy_cyc", busy_cnt, (e.n == 0) ? 2 : e.n * 10 + 1);
          chk("done_ack", int'(ack_cnt), e.ack);
        end
        last_ev   = cyc;
        have_last = 1;
        in_burst  = 0;
      end
    end
  end

  initial begin
    bit seen;
    // 1: reset hold with a pending request
    #5 rst = 1'b0;
    req0 = 1'b1;
    num0 = 4'd3;
    repeat (30) @(negedge clk);
    chk("rst_count_o", int'(count_o), 0);
    chk("rst_gnt", int'({gnt1, gnt0}), 0);
    chk("rst_done", int'({done1, done0}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack_cnt), 0);

    // 2: single burst of 3 from requester 0
    push(0, 0, -1, 0, 0);
    push(1, 0, 30, 3, 0);
    rst = 1'b1;
    wait_for(0, 20);
    req0 = 1'b0;
    wait_for(2, 60);
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // 3: contention from reset, num=2 each
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b1; num0 = 4'd2;
    req1 = 1'b1; num1 = 4'd2;
    push(0, 0, -1, 0, 0);
    push(1, 0, 20, 2, 0);
    push(0, 1, 2, 0, 0);
    push(1, 1, 20, 2, 0);
    push(0, 0, 2, 0, 0);
    push(1, 0, 20, 2, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_for(0, 20);
    wait_for(2, 60);
    wait_for(3, 60);
    wait_for(0, 20);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_for(2, 60);
    repeat (3) @(negedge clk);

    // 4: zero-length burst on requester 1
    push(0, 1, -1, 0, 0);
    push(1, 1, 1, 0, 0);
    req1 = 1'b1;
    num1 = 4'd0;
    wait_for(1, 20);
    req1 = 1'b0;
    wait_for(3, 10);
    repeat (3) @(negedge clk);

    // 5a: acknowledge echo, num=4
    echo_en = 1'b1;
    push(0, 0, -1, 0, 0);
    push(1, 0, 40, 4, 4);
    req0 = 1'b1;
    num0 = 4'd4;
    wait_for(0, 20);
    req0 = 1'b0;
    wait_for(2, 80);
    repeat (3) @(negedge clk);
    chk("ack_hold", int'(ack_cnt), 4);
    echo_en = 1'b0;
    cnt_man = 1'b0;

    // 5b: saturation, num=15 with a fast cnt_i toggle (well over 16 edges)
    push(0, 1, -1, 0, 0);
    push(1, 1, 150, 15, 15);
    req1 = 1'b1;
    num1 = 4'd15;
    wait_for(1, 20);
    req1 = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done1) seen = 1;
      if (k % 2 == 0) cnt_man = ~cnt_man;
    end
    if (!seen) chk("timeout_sat", 0, 1);
    cnt_man = 1'b0;
    repeat (3) @(negedge clk);

    // 6: reset in the 2nd HIGH phase of a num=3 burst
    push(0, 0, -1, 0, 0);
    req0 = 1'b1;
    num0 = 4'd3;
    wait_for(0, 20);
    repeat (12) @(negedge clk);
    chk("pre_rst_count_o", int'(count_o), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_count_o", int'(count_o), 0);
    chk("mid_rst_busy", int'(busy), 0);
    req1 = 1'b1;
    num0 = 4'd1;
    num1 = 4'd1;
    push(0, 0, -1, 0, 0);
    push(1, 0, 10, 1, 0);
    push(0, 1, 2, 0, 0);
    push(1, 1, 10, 1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_for(0, 20);
    wait_for(1, 40);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_for(3, 40);
    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
